// File: rtl/count_checker_pkg.sv
// Shared types and widths for the count checker.
package count_checker_pkg;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned MISS_CNT_W = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    CHECK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; increments stop at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Shadows an external counter, predicts its value each cycle and flags mismatches.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned INCR       = 1,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     expected,
  output logic                 locked,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap
);

  localparam logic [WIDTH-1:0]      INCR_W    = WIDTH'(INCR);
  localparam logic [MISS_CNT_W-1:0] MISS_LAST = MISS_CNT_W'(MISS_LIMIT - 1);

  state_t                state;
  state_t                state_nxt;
  logic [WIDTH-1:0]      expected_nxt;
  logic                  err_nxt;
  logic                  err_sticky_nxt;
  logic                  wrap_nxt;
  logic                  err_inc_c;
  logic                  miss_inc_c;
  logic                  miss_clr_c;
  logic [MISS_CNT_W-1:0] miss_cnt;
  logic                  mismatch_c;
  logic [WIDTH:0]        exp_sum_c;
  logic [WIDTH-1:0]      resync_c;

  // Comparison and next-value arithmetic shared by the FSM.
  always_comb begin
    mismatch_c = (cnt_in != expected);
    exp_sum_c  = {1'b0, expected} + {1'b0, INCR_W};
    resync_c   = load ? data_in : (cnt_in + INCR_W);
  end

  // Next-state, prediction and error flag logic.
  always_comb begin
    state_nxt      = state;
    expected_nxt   = expected;
    err_nxt        = 1'b0;
    err_sticky_nxt = err_sticky;
    wrap_nxt       = 1'b0;
    err_inc_c      = 1'b0;
    miss_inc_c     = 1'b0;
    miss_clr_c     = 1'b0;

    if (clr) begin
      state_nxt      = SYNC;
      err_sticky_nxt = 1'b0;
      miss_clr_c     = 1'b1;
    end else begin
      case (state)
        SYNC: begin
          expected_nxt = resync_c;
          state_nxt    = CHECK;
        end
        CHECK: begin
          wrap_nxt = !load && exp_sum_c[WIDTH];
          if (mismatch_c) begin
            err_nxt        = 1'b1;
            err_sticky_nxt = 1'b1;
            err_inc_c      = 1'b1;
            miss_inc_c     = 1'b1;
            expected_nxt   = resync_c;
            if (miss_cnt == MISS_LAST) begin
              state_nxt = FAULT;
            end
          end else begin
            miss_clr_c   = 1'b1;
            expected_nxt = load ? data_in : exp_sum_c[WIDTH-1:0];
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = SYNC;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      expected   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      expected   <= expected_nxt;
      locked     <= (state_nxt == CHECK);
      err        <= err_nxt;
      err_sticky <= err_sticky_nxt;
      wrap       <= wrap_nxt;
    end
  end

  // Total mismatch count, saturating.
  sat_counter #(
    .WIDTH(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (err_inc_c),
    .count(err_count)
  );

  // Consecutive mismatch count, cleared by any match or clr.
  sat_counter #(
    .WIDTH(MISS_CNT_W)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (miss_clr_c),
    .inc  (miss_inc_c),
    .count(miss_cnt)
  );

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker with directed vectors (WIDTH=5, INCR=1, MISS_LIMIT=3).
module tb_count_checker;

  typedef struct packed {
    logic [4:0] exp;
    logic       locked;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
    logic       wrap;
  } out_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic [4:0] data_in;
  logic [4:0] cnt_in;
  logic       clr;
  logic [4:0] expected;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_count;
  logic       wrap;

  logic       probe;
  logic       done;

  out_t  exp_q[$];
  string name_q[$];
  int    n_chk;
  int    n_fail;

  count_checker #(
    .WIDTH     (5),
    .INCR      (1),
    .MISS_LIMIT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .expected  (expected),
    .locked    (locked),
    .err       (err),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t mk(input logic [4:0] e, input logic l, input logic er,
                              input logic s, input logic [7:0] c, input logic w);
    out_t o;
    o.exp    = e;
    o.locked = l;
    o.err    = er;
    o.sticky = s;
    o.cnt    = c;
    o.wrap   = w;
    return o;
  endfunction

  // Monitor: compares DUT outputs against queued expectations away from the active edge.
  initial begin
    out_t act;
    out_t req;
    string nm;
    n_chk  = 0;
    n_fail = 0;
    forever begin
      @(negedge clk or posedge probe or posedge done);
      act = mk(expected, locked, err, err_sticky, err_count, wrap);
      if (done) begin
        n_chk++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
      end else begin
        if (probe) begin
          req = mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
          nm  = "async_reset";
        end else if (exp_q.size() != 0) begin
          req = exp_q.pop_front();
          nm  = name_q.pop_front();
        end else begin
          continue;
        end
        n_chk++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s: got exp=%0d locked=%0b err=%0b sticky=%0b cnt=%0d wrap=%0b, required exp=%0d locked=%0b err=%0b sticky=%0b cnt=%0d wrap=%0b",
                   nm, act.exp, act.locked, act.err, act.sticky, act.cnt, act.wrap,
                   req.exp, req.locked, req.err, req.sticky, req.cnt, req.wrap);
        end
      end
    end
  end

  // One clock of stimulus; the expectation describes outputs after this edge.
  task automatic step(input logic ld, input logic [4:0] d, input logic [4:0] c,
                      input logic cl, input out_t e, input string nm);
    load    = ld;
    data_in = d;
    cnt_in  = c;
    clr     = cl;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int e;
    int ce;
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    cnt_in  = '0;
    clr     = 1'b0;
    probe   = 1'b0;
    done    = 1'b0;
    exp_q.push_back(mk(5'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    name_q.push_back("reset");
    @(negedge clk);
    rst = 1'b0;

    // Track a plain counter from reset release.
    step(1'b0, 5'd0, 5'd0, 1'b0, mk(5'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "sync_capture");
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 5'd0, 5'(i), 1'b0, mk(5'(i + 1), 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "track");
    end

    // Load 12 while at 7, then 12,13,14.
    step(1'b1, 5'd12, 5'd7, 1'b0, mk(5'd12, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "load12");
    step(1'b0, 5'd0, 5'd12, 1'b0, mk(5'd13, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "after_load");
    step(1'b0, 5'd0, 5'd13, 1'b0, mk(5'd14, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "after_load");
    step(1'b0, 5'd0, 5'd14, 1'b0, mk(5'd15, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "after_load");

    // Jump to 29 and run across the wrap.
    step(1'b1, 5'd29, 5'd15, 1'b0, mk(5'd29, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "load29");
    step(1'b0, 5'd0, 5'd29, 1'b0, mk(5'd30, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "wrap_29");
    step(1'b0, 5'd0, 5'd30, 1'b0, mk(5'd31, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "wrap_30");
    step(1'b0, 5'd0, 5'd31, 1'b0, mk(5'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1), "wrap_31");
    step(1'b0, 5'd0, 5'd0, 1'b0, mk(5'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "wrap_0");
    step(1'b0, 5'd0, 5'd1, 1'b0, mk(5'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "wrap_1");

    // Single glitch: 9 where 5 is expected, then 10,11.
    step(1'b0, 5'd0, 5'd2, 1'b0, mk(5'd3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "pre_glitch");
    step(1'b0, 5'd0, 5'd3, 1'b0, mk(5'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "pre_glitch");
    step(1'b0, 5'd0, 5'd4, 1'b0, mk(5'd5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "pre_glitch");
    step(1'b0, 5'd0, 5'd9, 1'b0, mk(5'd10, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0), "glitch");
    step(1'b0, 5'd0, 5'd10, 1'b0, mk(5'd11, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0), "post_glitch");
    step(1'b0, 5'd0, 5'd11, 1'b0, mk(5'd12, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0), "post_glitch");

    // clr together with a mismatch: clr wins, then SYNC capture.
    step(1'b0, 5'd0, 5'd20, 1'b1, mk(5'd12, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0), "clr_vs_miss");
    step(1'b0, 5'd0, 5'd12, 1'b0, mk(5'd13, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "resync");

    // Stuck at 4: three misses force FAULT, fourth is ignored.
    step(1'b0, 5'd0, 5'd4, 1'b0, mk(5'd5, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0), "stuck_1");
    step(1'b0, 5'd0, 5'd4, 1'b0, mk(5'd5, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0), "stuck_2");
    step(1'b0, 5'd0, 5'd4, 1'b0, mk(5'd5, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0), "stuck_3_fault");
    step(1'b0, 5'd0, 5'd4, 1'b0, mk(5'd5, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0), "fault_hold");
    step(1'b0, 5'd0, 5'd4, 1'b1, mk(5'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0), "fault_clr");
    step(1'b0, 5'd0, 5'd20, 1'b0, mk(5'd21, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "clr_resync");

    // Load coinciding with a mismatch.
    step(1'b1, 5'd3, 5'd7, 1'b0, mk(5'd3, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0), "load_miss");
    step(1'b0, 5'd0, 5'd3, 1'b0, mk(5'd4, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0), "load_miss_next");

    // Alternate miss/match to drive err_count into saturation.
    e  = 4;
    ce = 1;
    for (int i = 0; i < 256; i++) begin
      ce = (ce < 255) ? ce + 1 : 255;
      step(1'b0, 5'd0, 5'(e + 2), 1'b0,
           mk(5'(e + 3), 1'b1, 1'b1, 1'b1, 8'(ce), 1'b0), "sat_miss");
      step(1'b0, 5'd0, 5'(e + 3), 1'b0,
           mk(5'(e + 4), 1'b1, 1'b0, 1'b1, 8'(ce), (e == 28) ? 1'b1 : 1'b0), "sat_match");
      e = (e + 4) % 32;
    end

    // Asynchronous reset between edges, then SYNC capture on release.
    #2;
    rst = 1'b1;
    #1;
    probe = 1'b1;
    #1;
    probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 5'd0, 5'd9, 1'b0, mk(5'd10, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "post_rst_sync");
    step(1'b0, 5'd0, 5'd10, 1'b0, mk(5'd11, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "post_rst_track");

    @(negedge clk);
    #1;
    done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
